// File: rtl/rs_pkg.sv
// Shared types for the age-ordered issue queue.
// Default widths, the entry record and a tag compare helper.
package rs_pkg;

   localparam int DEF_OPC_W = 5;
   localparam int DEF_TAG_W = 6;

   typedef struct packed {
      logic                 valid;
      logic [DEF_OPC_W-1:0] opcode;
      logic [DEF_TAG_W-1:0] src1_tag;
      logic                 src1_rdy;
      logic [DEF_TAG_W-1:0] src2_tag;
      logic                 src2_rdy;
      logic [DEF_TAG_W-1:0] dest;
   } rs_entry_t;

   function automatic logic tag_eq(
      input logic [DEF_TAG_W-1:0] a,
      input logic [DEF_TAG_W-1:0] b
   );
      return a == b;
   endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Pairwise age matrix: older_q[i][j] means entry i is older than j.
// Grants the single candidate that no other candidate is older than.
module rs_age_matrix
   import rs_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic [DEPTH-1:0] valid,
   input  logic [DEPTH-1:0] alloc,
   input  logic [DEPTH-1:0] cand,
   output logic [DEPTH-1:0] grant,
   output logic             any_grant
);

   logic [DEPTH-1:0] older_q [DEPTH];

   // Oldest candidate: no other candidate holds an older bit over it.
   always_comb begin
      grant = '0;
      for (int j = 0; j < DEPTH; j++) begin
         grant[j] = cand[j];
         for (int i = 0; i < DEPTH; i++) begin
            if (cand[i] && older_q[i][j]) begin
               grant[j] = 1'b0;
            end
         end
      end
   end

   assign any_grant = |grant;

   // New entry becomes younger than every live entry; its own row clears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            older_q[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            older_q[i] <= '0;
         end
      end else begin
         for (int n = 0; n < DEPTH; n++) begin
            if (alloc[n]) begin
               older_q[n] <= '0;
               for (int i = 0; i < DEPTH; i++) begin
                  if (valid[i]) begin
                     older_q[i][n] <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/rs_age_issue_queue.sv
// Reservation station with CDB wakeup and oldest-ready issue.
// Insert goes to the lowest free slot; age matrix picks the winner.
module rs_age_issue_queue
   import rs_pkg::*;
#(
   parameter int RS_DEPTH = 8,
   parameter int OPC_W    = DEF_OPC_W,
   parameter int TAG_W    = DEF_TAG_W,
   parameter int NUM_CDB  = 2,
   parameter int CNT_W    = $clog2(RS_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     insert_valid,
   output logic                     insert_ready,
   input  logic [OPC_W-1:0]         insert_opcode,
   input  logic [TAG_W-1:0]         insert_src1_tag,
   input  logic [TAG_W-1:0]         insert_src2_tag,
   input  logic                     insert_src1_rdy,
   input  logic                     insert_src2_rdy,
   input  logic [TAG_W-1:0]         insert_dest_tag,
   input  logic [NUM_CDB-1:0]       cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
   output logic                     issue_valid,
   input  logic                     issue_ready,
   output logic [OPC_W-1:0]         issue_opcode,
   output logic [TAG_W-1:0]         issue_src1_tag,
   output logic [TAG_W-1:0]         issue_src2_tag,
   output logic [TAG_W-1:0]         issue_dest_tag,
   output logic [CNT_W-1:0]         occupancy
);

   rs_entry_t ent_q [RS_DEPTH];
   rs_entry_t new_ent;

   logic [CNT_W-1:0]    occ_q;
   logic [RS_DEPTH-1:0] vld;
   logic [RS_DEPTH-1:0] cand;
   logic [RS_DEPTH-1:0] free_oh;
   logic [RS_DEPTH-1:0] alloc_oh;
   logic [RS_DEPTH-1:0] grant;
   logic [RS_DEPTH-1:0] hit1;
   logic [RS_DEPTH-1:0] hit2;
   logic                found;
   logic                any_grant;
   logic                ins_hit1;
   logic                ins_hit2;
   logic                ins_fire;
   logic                iss_fire;

   assign insert_ready = occ_q < CNT_W'(RS_DEPTH);
   assign ins_fire     = insert_valid && insert_ready && !flush;
   assign iss_fire     = any_grant && issue_ready && !flush;
   assign issue_valid  = any_grant;
   assign occupancy    = occ_q;
   assign alloc_oh     = ins_fire ? free_oh : '0;

   // Per-entry valid and candidate vectors from registered state.
   always_comb begin
      vld  = '0;
      cand = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         vld[i]  = ent_q[i].valid;
         cand[i] = ent_q[i].valid && ent_q[i].src1_rdy
                   && ent_q[i].src2_rdy;
      end
   end

   // Lowest-index free slot.
   always_comb begin
      free_oh = '0;
      found   = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (!vld[i] && !found) begin
            free_oh[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   // CDB tag compare for stored entries and the incoming op.
   always_comb begin
      hit1     = '0;
      hit2     = '0;
      ins_hit1 = 1'b0;
      ins_hit2 = 1'b0;
      for (int k = 0; k < NUM_CDB; k++) begin
         if (cdb_valid[k]) begin
            if (tag_eq(insert_src1_tag, cdb_tag[k*TAG_W +: TAG_W])) begin
               ins_hit1 = 1'b1;
            end
            if (tag_eq(insert_src2_tag, cdb_tag[k*TAG_W +: TAG_W])) begin
               ins_hit2 = 1'b1;
            end
            for (int i = 0; i < RS_DEPTH; i++) begin
               if (tag_eq(ent_q[i].src1_tag, cdb_tag[k*TAG_W +: TAG_W])) begin
                  hit1[i] = 1'b1;
               end
               if (tag_eq(ent_q[i].src2_tag, cdb_tag[k*TAG_W +: TAG_W])) begin
                  hit2[i] = 1'b1;
               end
            end
         end
      end
   end

   // Incoming entry with same-cycle CDB bypass folded into ready bits.
   always_comb begin
      new_ent          = '0;
      new_ent.valid    = 1'b1;
      new_ent.opcode   = insert_opcode;
      new_ent.src1_tag = insert_src1_tag;
      new_ent.src1_rdy = insert_src1_rdy || ins_hit1;
      new_ent.src2_tag = insert_src2_tag;
      new_ent.src2_rdy = insert_src2_rdy || ins_hit2;
      new_ent.dest     = insert_dest_tag;
   end

   // Issue data mux; zero when no entry is granted.
   always_comb begin
      issue_opcode   = '0;
      issue_src1_tag = '0;
      issue_src2_tag = '0;
      issue_dest_tag = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (grant[i]) begin
            issue_opcode   = ent_q[i].opcode;
            issue_src1_tag = ent_q[i].src1_tag;
            issue_src2_tag = ent_q[i].src2_tag;
            issue_dest_tag = ent_q[i].dest;
         end
      end
   end

   // Entry state: flush beats insert, issue and wakeup.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         occ_q <= '0;
      end else if (flush) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            ent_q[i].valid <= 1'b0;
         end
         occ_q <= '0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (alloc_oh[i]) begin
               ent_q[i] <= new_ent;
            end else if (iss_fire && grant[i]) begin
               ent_q[i].valid <= 1'b0;
            end else if (ent_q[i].valid) begin
               if (hit1[i]) begin
                  ent_q[i].src1_rdy <= 1'b1;
               end
               if (hit2[i]) begin
                  ent_q[i].src2_rdy <= 1'b1;
               end
            end
         end
         occ_q <= occ_q + CNT_W'(ins_fire) - CNT_W'(iss_fire);
      end
   end

   rs_age_matrix #(
      .DEPTH (RS_DEPTH)
   ) u_age (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .valid     (vld),
      .alloc     (alloc_oh),
      .cand      (cand),
      .grant     (grant),
      .any_grant (any_grant)
   );

endmodule

// File: tb/tb_rs_age_issue_queue.sv
// Scoreboard bench for the age-ordered issue queue.
// Stimulus queues expected issues; a monitor checks each handshake.
module tb_rs_age_issue_queue;

   localparam int D  = 8;
   localparam int OW = 5;
   localparam int TW = 6;
   localparam int NC = 2;
   localparam int CW = 4;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           flush;
   logic           insert_valid;
   logic           insert_ready;
   logic [OW-1:0]  insert_opcode;
   logic [TW-1:0]  insert_src1_tag;
   logic [TW-1:0]  insert_src2_tag;
   logic           insert_src1_rdy;
   logic           insert_src2_rdy;
   logic [TW-1:0]  insert_dest_tag;
   logic [NC-1:0]  cdb_valid;
   logic [NC*TW-1:0] cdb_tag;
   logic           issue_valid;
   logic           issue_ready;
   logic [OW-1:0]  issue_opcode;
   logic [TW-1:0]  issue_src1_tag;
   logic [TW-1:0]  issue_src2_tag;
   logic [TW-1:0]  issue_dest_tag;
   logic [CW-1:0]  occupancy;

   typedef struct packed {
      logic [OW-1:0] opc;
      logic [TW-1:0] s1;
      logic [TW-1:0] s2;
      logic [TW-1:0] d;
   } rec_t;

   rec_t exp_q[$];
   rec_t e_rec;
   rec_t g_rec;
   int   checks   = 0;
   int   failures = 0;

   rs_age_issue_queue #(
      .RS_DEPTH (D),
      .OPC_W    (OW),
      .TAG_W    (TW),
      .NUM_CDB  (NC)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .flush           (flush),
      .insert_valid    (insert_valid),
      .insert_ready    (insert_ready),
      .insert_opcode   (insert_opcode),
      .insert_src1_tag (insert_src1_tag),
      .insert_src2_tag (insert_src2_tag),
      .insert_src1_rdy (insert_src1_rdy),
      .insert_src2_rdy (insert_src2_rdy),
      .insert_dest_tag (insert_dest_tag),
      .cdb_valid       (cdb_valid),
      .cdb_tag         (cdb_tag),
      .issue_valid     (issue_valid),
      .issue_ready     (issue_ready),
      .issue_opcode    (issue_opcode),
      .issue_src1_tag  (issue_src1_tag),
      .issue_src2_tag  (issue_src2_tag),
      .issue_dest_tag  (issue_dest_tag),
      .occupancy       (occupancy)
   );

   always #5 clk = ~clk;

   function automatic rec_t mk(input int op, input int s1,
                               input int s2, input int d);
      rec_t r;
      r.opc = OW'(op);
      r.s1  = TW'(s1);
      r.s2  = TW'(s2);
      r.d   = TW'(d);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ins(input int op, input int s1, input logic r1,
                          input int s2, input logic r2, input int d);
      insert_valid    = 1'b1;
      insert_opcode   = OW'(op);
      insert_src1_tag = TW'(s1);
      insert_src1_rdy = r1;
      insert_src2_tag = TW'(s2);
      insert_src2_rdy = r2;
      insert_dest_tag = TW'(d);
   endtask

   task automatic push(input int op, input int s1,
                       input int s2, input int d);
      exp_q.push_back(mk(op, s1, s2, d));
   endtask

   // Monitor: every accepted issue must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset_n && insert_valid && !insert_ready && !flush) begin
         $display("note: insert offered while insert_ready=0, ignored");
      end
      if (reset_n && !flush && issue_valid && issue_ready) begin
         checks++;
         g_rec = mk(int'(issue_opcode), int'(issue_src1_tag),
                    int'(issue_src2_tag), int'(issue_dest_tag));
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL issue_unexpected: got op=%0d dest=%0d expected none",
                     g_rec.opc, g_rec.d);
         end else begin
            e_rec = exp_q.pop_front();
            if (g_rec !== e_rec) begin
               failures++;
               $display("FAIL issue_order: got op=%0d s1=%0d s2=%0d d=%0d expected op=%0d s1=%0d s2=%0d d=%0d",
                        g_rec.opc, g_rec.s1, g_rec.s2, g_rec.d,
                        e_rec.opc, e_rec.s1, e_rec.s2, e_rec.d);
            end
         end
      end
   end

   initial begin
      reset_n         = 1'b0;
      flush           = 1'b0;
      insert_valid    = 1'b0;
      insert_opcode   = '0;
      insert_src1_tag = '0;
      insert_src2_tag = '0;
      insert_src1_rdy = 1'b0;
      insert_src2_rdy = 1'b0;
      insert_dest_tag = '0;
      cdb_valid       = '0;
      cdb_tag         = '0;
      issue_ready     = 1'b0;

      #3;
      chk("rst_insert_ready", 32'(insert_ready), 1);
      chk("rst_issue_valid", 32'(issue_valid), 0);
      chk("rst_occupancy", 32'(occupancy), 0);
      chk("rst_issue_opcode", 32'(issue_opcode), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Fill to capacity with ready ops
      for (int i = 0; i < D; i++) begin
         set_ins(i, i, 1'b1, i + 20, 1'b1, i + 10);
         tick();
      end
      insert_valid = 1'b0;
      chk("fill_occ", 32'(occupancy), 8);
      chk("fill_ready", 32'(insert_ready), 0);

      set_ins(9, 3, 1'b1, 4, 1'b1, 63);
      tick();
      insert_valid = 1'b0;
      chk("ninth_dropped_occ", 32'(occupancy), 8);
      chk("fill_oldest_op", 32'(issue_opcode), 0);
      chk("fill_oldest_dest", 32'(issue_dest_tag), 10);

      // Full queue: issue frees a slot, insert follows next cycle
      push(0, 0, 20, 10);
      push(1, 1, 21, 11);
      issue_ready = 1'b1;
      set_ins(20, 1, 1'b1, 2, 1'b1, 30);
      tick();
      chk("full_issue_occ", 32'(occupancy), 7);
      chk("full_issue_ready", 32'(insert_ready), 1);
      tick();
      insert_valid = 1'b0;
      issue_ready  = 1'b0;
      chk("ins_iss_same_occ", 32'(occupancy), 7);

      for (int i = 2; i < D; i++) begin
         push(i, i, i + 20, i + 10);
      end
      push(20, 1, 2, 30);
      issue_ready = 1'b1;
      repeat (7) tick();
      issue_ready = 1'b0;
      chk("drain_occ", 32'(occupancy), 0);
      chk("drain_issue_valid", 32'(issue_valid), 0);
      chk("idle_opcode_zero", 32'(issue_opcode), 0);
      chk("idle_dest_zero", 32'(issue_dest_tag), 0);

      // Age order: A waits on tag 5, B and C ready
      set_ins(1, 5, 1'b0, 0, 1'b1, 40);
      tick();
      set_ins(2, 6, 1'b1, 7, 1'b1, 41);
      tick();
      set_ins(3, 8, 1'b1, 9, 1'b1, 42);
      tick();
      insert_valid = 1'b0;
      chk("age_b_presented", 32'(issue_opcode), 2);
      cdb_valid = 2'b01;
      cdb_tag   = {6'd0, 6'd5};
      @(negedge clk);
      chk("age_b_during_cdb", 32'(issue_opcode), 2);
      tick();
      cdb_valid = '0;
      chk("age_a_wins", 32'(issue_opcode), 1);
      chk("age_occ", 32'(occupancy), 3);
      push(1, 5, 0, 40);
      push(2, 6, 7, 41);
      push(3, 8, 9, 42);
      issue_ready = 1'b1;
      repeat (3) tick();
      issue_ready = 1'b0;
      chk("age_drain_occ", 32'(occupancy), 0);

      // Dual CDB wakeup of both sources in one cycle
      set_ins(4, 12, 1'b0, 17, 1'b0, 50);
      tick();
      insert_valid = 1'b0;
      chk("dual_wait", 32'(issue_valid), 0);
      cdb_valid = 2'b11;
      cdb_tag   = {6'd17, 6'd12};
      @(negedge clk);
      chk("dual_no_comb", 32'(issue_valid), 0);
      tick();
      cdb_valid = '0;
      chk("dual_ready", 32'(issue_valid), 1);
      chk("dual_dest", 32'(issue_dest_tag), 50);
      push(4, 12, 17, 50);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;

      // Insert-time bypass from CDB port 1
      set_ins(6, 2, 1'b1, 9, 1'b0, 55);
      cdb_valid = 2'b10;
      cdb_tag   = {6'd9, 6'd33};
      tick();
      insert_valid = 1'b0;
      cdb_valid    = '0;
      chk("bypass_ready", 32'(issue_valid), 1);
      chk("bypass_dest", 32'(issue_dest_tag), 55);
      push(6, 2, 9, 55);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      chk("bypass_occ", 32'(occupancy), 0);

      // Flush with concurrent insert
      for (int i = 0; i < 5; i++) begin
         set_ins(10 + i, i, 1'b1, i, 1'b1, 20 + i);
         tick();
      end
      insert_valid = 1'b0;
      chk("pre_flush_occ", 32'(occupancy), 5);
      set_ins(15, 1, 1'b1, 1, 1'b1, 25);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_cycle_occ", 32'(occupancy), 5);
      chk("flush_cycle_valid", 32'(issue_valid), 1);
      tick();
      flush        = 1'b0;
      insert_valid = 1'b0;
      chk("flush_occ", 32'(occupancy), 0);
      chk("flush_issue_valid", 32'(issue_valid), 0);
      chk("flush_insert_ready", 32'(insert_ready), 1);
      tick();
      chk("flush_insert_dropped", 32'(occupancy), 0);

      // Asynchronous reset pulse mid-operation
      for (int i = 0; i < 3; i++) begin
         set_ins(16 + i, i, 1'b1, i, 1'b1, 30 + i);
         tick();
      end
      insert_valid = 1'b0;
      chk("pre_reset_occ", 32'(occupancy), 3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_occ", 32'(occupancy), 0);
      chk("async_rst_valid", 32'(issue_valid), 0);
      chk("async_rst_ready", 32'(insert_ready), 1);
      #3;
      reset_n = 1'b1;
      tick();
      chk("post_rst_occ", 32'(occupancy), 0);

      set_ins(7, 1, 1'b1, 2, 1'b1, 60);
      tick();
      insert_valid = 1'b0;
      push(7, 1, 2, 60);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      chk("post_rst_issue_occ", 32'(occupancy), 0);

      tick();
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
